uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Serial UART transmitter: the return-direction counterpart of the CS block's UART receiver. Sends 8-bit payloads back to the host as fixed 12-bit frames.
- Line rate is 9600 baud or 4800 baud, chosen by baud_sel. The upstream producer is a status/echo source inside CS, or a testbench driver.
- Upstream handshake is valid/ready. The serial line idles high.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per bit at 9600 baud (100 MHz / 9600); the 4800-baud divisor is 2*CLKS_PER_BIT.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- tx_valid  in  1  producer has a byte on tx_data.
- tx_data  in  8  payload byte; sampled on acceptance.
- tx_ready  out  1  high only in IDLE; a frame is accepted when tx_valid && tx_ready at a clk edge.
- baud_sel  in  1  0 = 9600 baud, 1 = 4800 baud; sampled on acceptance only.
- tx  out  1  serial line; 1 when idle.
- busy  out  1  high from the cycle after acceptance until the frame completes.
- done  out  1  single-cycle pulse on the cycle the frame completes.

Behaviour:
- Frame layout (12 bits, in send order):
  - start bit = 0;
  - data[0]..data[7], LSB first;
  - parity bit = ^data, XORed with PARITY_ODD;
  - stop bit 1 = 1;
  - stop bit 2 = 1.
- Every bit is held for exactly D clk cycles: D = CLKS_PER_BIT when the latched baud_sel = 0, D = 2*CLKS_PER_BIT when it = 1.
- Reset (rst_n = 0 at a clk edge):
  - state = IDLE; tx = 1, tx_ready = 1, busy = 0, done = 0;
  - bit/cycle counters and data shift register cleared.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on accept, latch tx_data, baud_sel and computed parity; go to START. tx falls to 0 on the first cycle after the accept edge (latency 1).
  - START → DATA after D cycles.
  - DATA shifts out 8 bits, D cycles each, then → PARITY.
  - PARITY → STOP after D cycles.
  - STOP lasts 2*D cycles. At its end: state = IDLE, done = 1 for that one cycle, busy = 0, tx_ready = 1.
- Frame length from first start-bit cycle to end of stop is exactly 12*D cycles.
- Back-to-back frames: if tx_valid is high while tx_ready = 1, the next start bit begins the following cycle, giving a minimum idle gap of 1 cycle (tx = 1).
- While busy:
  - tx_valid is ignored; the producer holds tx_data until accepted.
  - Changes on tx_data and baud_sel do not affect the frame in flight.
- Counter width: cycle counter is $clog2(2*CLKS_PER_BIT) bits and counts 0..D-1. The bit advances when count == D-1; the counter then wraps to 0.
- Bit counter is 3 bits in DATA and wraps 7→0 on the exit to PARITY.
- Reset mid-frame: the frame is aborted, tx returns to 1 on that edge and no done pulse is produced. The next accept after reset starts a clean frame.
- All outputs are registered; tx must be glitch-free.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - FRAME_BITS = 12, DATA_BITS = 8, STOP_BITS = 2;
  - default CLKS_PER_BIT;
  - the same frame constants shared with the CS receiver.
- One sub-module, uart_baud_gen: cycle counter with a divisor select. It emits bit_tick every D cycles, is cleared on frame start, and its divisor is latched at accept.
- FSM and shift register stay in uart_tx_frame.

Test Plan (sim with CLKS_PER_BIT = 16):
1. Reset for 5 cycles, then release, with no stimulus → tx = 1, tx_ready = 1, busy = 0, done = 0 for 100 cycles.
2. Send tx_data = 8'hA5, baud_sel = 0, even parity:
   - line sequence 0,1,0,1,0,0,1,0,1,0,1,1, each bit 16 cycles;
   - done pulses exactly 192 cycles after the first start-bit cycle.
3. Send tx_data = 8'h07, baud_sel = 1, PARITY_ODD = 0:
   - parity bit = 1, each bit 32 cycles, frame 384 cycles;
   - toggling baud_sel at cycle 100 leaves bit timing unchanged.
4. Hold tx_valid high with 8'h3C then 8'hFF queued:
   - second start bit begins 1 cycle after the first done;
   - tx_valid pulses while busy are not accepted (tx_ready = 0 throughout).
5. Assert rst_n = 0 during data bit 4 of 8'h81:
   - tx = 1, tx_ready = 1 on the next edge, no done pulse;
   - a new 8'h81 frame afterwards is bit-exact.
6. PARITY_ODD = 1 with tx_data = 8'h00 → parity bit = 1; with 8'h01 → parity bit = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, FSM state type and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int FRAME_BITS           = 12;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 2;
    localparam int DEFAULT_CLKS_PER_BIT = 10417;

    function automatic logic frame_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter; divisor (D or 2*D) latched on clear
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    input  logic baud_sel,
    output logic bit_tick
);

    localparam int CW = $clog2(2 * CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_FAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LAST_SLOW = CW'(2 * CLKS_PER_BIT - 1);

    logic [CW-1:0] count;
    logic          slow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            slow  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            slow  <= baud_sel;
        end else if (run) begin
            if (bit_tick)
                count <= '0;
            else
                count <= count + CW'(1);
        end
    end

    assign bit_tick = run && (count == (slow ? LAST_SLOW : LAST_FAST));

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - 12-bit frame UART transmitter (start, 8 data, parity, 2 stop)
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       baud_sel,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    uart_state_t          state, state_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 parity, parity_next;
    logic [2:0]           bit_cnt, bit_cnt_next;
    logic                 tx_next, busy_next, done_next;
    logic                 accept, bit_tick;

    assign accept = tx_valid && tx_ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .run     (state != IDLE),
        .baud_sel(baud_sel),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            parity   <= 1'b0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            parity   <= parity_next;
            bit_cnt  <= bit_cnt_next;
            tx       <= tx_next;
            tx_ready <= (state_next == IDLE);
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    // bit_cnt indexes data bits in DATA and is reused to count the two stop bits
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        parity_next  = parity;
        bit_cnt_next = bit_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next   = START;
                    shreg_next   = tx_data;
                    parity_next  = frame_parity(tx_data, PARITY_ODD);
                    bit_cnt_next = '0;
                end
            end
            START: begin
                if (bit_tick)
                    state_next = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_next   = {1'b0, shreg[DATA_BITS-1:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(DATA_BITS - 1))
                        state_next = PARITY;
                end
            end
            PARITY: begin
                if (bit_tick)
                    state_next = STOP;
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered tx leads with no extra cycle
    always_comb begin
        busy_next = (state_next != IDLE);
        done_next = (state == STOP) && (state_next == IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - randomized self-checking bench, even and odd parity instances
module tb_uart_tx_frame;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       baud_sel;
    logic       tx_e, ready_e, busy_e, done_e;
    logic       tx_o, ready_o, busy_o, done_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(ready_e), .baud_sel(baud_sel), .tx(tx_e), .busy(busy_e), .done(done_e)
    );

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(ready_o), .baud_sel(baud_sel), .tx(tx_o), .busy(busy_o), .done(done_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Line level of frame bit k: start, data LSB first, parity, two stops
    function automatic logic model_bit(input logic [7:0] data, input int k, input logic odd);
        if (k == 0) return 1'b0;
        if (k <= 8) return data[k-1];
        if (k == 9) return (^data) ^ odd;
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_tx_e"}, tx_e, 1);
        check({tag, "_tx_o"}, tx_o, 1);
        check({tag, "_ready"}, {ready_e, ready_o}, 2'b11);
        check({tag, "_busy"}, {busy_e, busy_o}, 2'b00);
        check({tag, "_done"}, {done_e, done_o}, 2'b00);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        tx_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            check_idle("idle");
        end
    endtask

    // Called on a negedge; returns on the negedge of the done cycle (or after an abort)
    task automatic send(input logic [7:0] data, input logic sel, input int abort_bit);
        int d;
        int k;
        d = sel ? 2 * CPB : CPB;
        tx_valid = 1'b1;
        tx_data  = data;
        baud_sel = sel;
        check("ready_before_accept", {ready_e, ready_o}, 2'b11);
        step();
        for (int c = 0; c < uart_pkg::FRAME_BITS * d; c++) begin
            k = c / d;
            if (k == abort_bit && (c % d) == d / 2) begin
                rst_n    = 1'b0;
                tx_valid = 1'b0;
                step();
                check_idle("abort");
                rst_n = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    step();
                    check_idle("post_abort");
                end
                return;
            end
            check("tx_even", tx_e, model_bit(data, k, 1'b0));
            check("tx_odd", tx_o, model_bit(data, k, 1'b1));
            check("busy_frame", {busy_e, busy_o}, 2'b11);
            check("ready_frame", {ready_e, ready_o}, 2'b00);
            check("done_early", {done_e, done_o}, 2'b00);
            tx_valid = 1'($urandom % 2);
            tx_data  = 8'($urandom);
            baud_sel = (c == 100) ? ~baud_sel : 1'($urandom % 2);
            step();
        end
        check("done_pulse", {done_e, done_o}, 2'b11);
        check("busy_end", {busy_e, busy_o}, 2'b00);
        check("ready_end", {ready_e, ready_o}, 2'b11);
        check("tx_end", {tx_e, tx_o}, 2'b11);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rs;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        baud_sel = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        idle(100);

        send(8'hA5, 1'b0, -1);
        idle(3);
        send(8'h07, 1'b1, -1);
        idle(2);
        send(8'h3C, 1'b0, -1);
        send(8'hFF, 1'b0, -1);
        idle(2);
        send(8'h81, 1'b0, 5);
        send(8'h81, 1'b0, -1);
        idle(1);
        send(8'h00, 1'b0, -1);
        send(8'h01, 1'b1, -1);
        idle(4);
        for (int i = 0; i < 8; i++) begin
            rd = 8'($urandom);
            rs = 1'($urandom % 2);
            send(rd, rs, -1);
            if ($urandom % 2 == 0)
                idle(1 + int'($urandom % 4));
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
